pipe_trace_buf: RTL

//   Hardware retire-trace buffer for the mips_32 pipeline. It is the producer side of the pipeline-state trace.

---
 rtl/mips32_trace_pkg.sv | 23 ++
 rtl/pipe_trace_fifo_mem.sv | 34 +++
 rtl/pipe_trace_buf.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mips32_trace_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips32_trace_pkg
// Description : Field widths and record type for the mips_32 retire trace.
// Revision    : 1.0 - initial release
// ============================================================================
package mips32_trace_pkg;

    localparam int TR_PC_W   = 32;
    localparam int TR_REG_W  = 5;
    localparam int TR_DATA_W = 32;
    localparam int TR_REC_W  = TR_PC_W + TR_REG_W + TR_DATA_W;

    // One retired write-back: pc, destination register, written value.
    // The register field is named rd because 'reg' is a reserved word.
    typedef struct packed {
        logic [TR_PC_W-1:0]   pc;
        logic [TR_REG_W-1:0]  rd;
        logic [TR_DATA_W-1:0] data;
    } trace_rec_t;

endpackage : mips32_trace_pkg
`default_nettype wire

// File: rtl/pipe_trace_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : pipe_trace_fifo_mem
// Description : DEPTH x trace record register array, one synchronous write
//               port and one asynchronous read port.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_trace_fifo_mem
    import mips32_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  trace_rec_t       i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output trace_rec_t       o_rdata
);

    trace_rec_t r_mem [DEPTH];

    // Storage write; contents need no reset since level gates their visibility.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : pipe_trace_fifo_mem
`default_nettype wire

// File: rtl/pipe_trace_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_trace_buf
// Description : Retire-trace FIFO for mips_32. Captures MEM/WB write-back
//               records and streams them out over valid/ready (FWFT).
//               Optional build macro TRACE_SKIP_R0_EN drops writes to $zero
//               before they reach the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_trace_buf
    import mips32_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic                     trace_clr,
    input  logic                     wb_valid,
    input  logic [TR_PC_W-1:0]       wb_pc,
    input  logic [TR_REG_W-1:0]      wb_reg,
    input  logic [TR_DATA_W-1:0]     wb_data,
    output logic                     tr_valid,
    input  logic                     tr_ready,
    output logic [TR_PC_W-1:0]       tr_pc,
    output logic [TR_REG_W-1:0]      tr_reg,
    output logic [TR_DATA_W-1:0]     tr_data,
    output logic [$clog2(DEPTH):0]   tr_level,
    output logic [CNT_W-1:0]         tr_drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [CNT_W-1:0] r_drop_cnt;
    trace_rec_t       r_hold;

    logic       w_filter_ok;
    logic       w_push;
    logic       w_pop;
    logic       w_empty;
    logic       w_full;
    logic       w_wr_en;
    logic       w_drop;
    trace_rec_t w_wr_rec;
    trace_rec_t w_rd_rec;
    trace_rec_t w_head;

`ifdef TRACE_SKIP_R0_EN
    assign w_filter_ok = (wb_reg != '0);
`else
    assign w_filter_ok = 1'b1;
`endif

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_push  = trace_en & wb_valid & w_filter_ok;
    // Clear overrides both sides of the FIFO in the same cycle.
    assign w_pop   = ~w_empty & tr_ready & ~trace_clr;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_wr_en = w_push & ~trace_clr & (~w_full | w_pop);
    assign w_drop  = w_push & ~trace_clr & w_full & ~w_pop;

    assign w_wr_rec = '{pc: wb_pc, rd: wb_reg, data: wb_data};

    pipe_trace_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_rec),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_rec)
    );

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (trace_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_wr_en && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_wr_en && w_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    // Saturating count of records lost to a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (trace_clr) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    // Remember the payload on display so it stays put once the FIFO empties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold <= '0;
        end else begin
            r_hold <= w_head;
        end
    end

    assign w_head      = w_empty ? r_hold : w_rd_rec;
    assign tr_valid    = ~w_empty;
    assign tr_pc       = w_head.pc;
    assign tr_reg      = w_head.rd;
    assign tr_data     = w_head.data;
    assign tr_level    = r_level;
    assign tr_drop_cnt = r_drop_cnt;

endmodule : pipe_trace_buf
`default_nettype wire
